// File: rtl/adventure_pkg.sv
// Shared world-map definitions: room list, screen size, direction and tracker state encodings.
// map_generator imports this package as well, so the room list has a single definition.
package adventure_pkg;

  localparam int SCREEN_W_PX = 640;
  localparam int SCREEN_H_PX = 480;

  localparam logic [3:0] START_CASTLE_X = 4'd3;
  localparam logic [3:0] START_CASTLE_Y = 4'd5;

  localparam int NUM_ROOMS = 12;
  localparam logic [3:0] ROOM_X [NUM_ROOMS] = '{
    4'd3, 4'd3, 4'd4, 4'd4, 4'd2, 4'd1, 4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd1
  };
  localparam logic [3:0] ROOM_Y [NUM_ROOMS] = '{
    4'd5, 4'd6, 4'd6, 4'd7, 4'd6, 4'd6, 4'd4, 4'd5, 4'd5, 4'd4, 4'd3, 4'd2
  };

  typedef enum logic [2:0] {
    DIR_NONE,
    DIR_N,
    DIR_S,
    DIR_W,
    DIR_E
  } dir_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_LOOKUP,
    ST_COMMIT,
    ST_WAIT_ACK,
    ST_HOLDOFF
  } tracker_state_t;

  function automatic logic room_exists(input logic [3:0] x, input logic [3:0] y);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < NUM_ROOMS; i++) begin
      if (ROOM_X[i] == x && ROOM_Y[i] == y) hit = 1'b1;
    end
    return hit;
  endfunction

endpackage

// File: rtl/edge_detect.sv
// Combinational screen-edge priority encoder: maps a sprite position to the exit direction.
module edge_detect
  import adventure_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_PX,
  parameter int SCREEN_H = SCREEN_H_PX,
  parameter int EDGE     = 4
) (
  input  logic [9:0] posX,
  input  logic [8:0] posY,
  output dir_t       dir
);

  localparam logic [9:0] X_LO = 10'(EDGE);
  localparam logic [9:0] X_HI = 10'(SCREEN_W - EDGE);
  localparam logic [8:0] Y_LO = 9'(EDGE);
  localparam logic [8:0] Y_HI = 9'(SCREEN_H - EDGE);

  // Corners resolve N > S > W > E so exactly one direction is reported.
  always_comb begin
    dir = DIR_NONE;
    if (posY < Y_LO)       dir = DIR_N;
    else if (posY >= Y_HI) dir = DIR_S;
    else if (posX < X_LO)  dir = DIR_W;
    else if (posX >= X_HI) dir = DIR_E;
  end

endmodule

// File: rtl/room_tracker.sv
// Per-frame room tracker: steps mapX/mapY when the player leaves the screen toward an existing
// room and hands the player module a re-entry position over a valid/ack handshake.
module room_tracker
  import adventure_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_PX,
  parameter int SCREEN_H = SCREEN_H_PX,
  parameter int EDGE     = 4,
  parameter int ENTRY    = 16,
  parameter int HOLDOFF  = 8,
  parameter int START_X  = int'(START_CASTLE_X),
  parameter int START_Y  = int'(START_CASTLE_Y)
) (
  input  logic       clk_vga,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic [9:0] playerX,
  input  logic [8:0] playerY,
  input  logic       warp_ack,
  output logic [3:0] mapX,
  output logic [3:0] mapY,
  output logic       warp_valid,
  output logic [9:0] warpX,
  output logic [8:0] warpY,
  output logic       busy
);

  localparam int HW = $clog2(HOLDOFF + 1);
  localparam logic [8:0] ENTRY_N = 9'(SCREEN_H - EDGE - ENTRY);
  localparam logic [8:0] ENTRY_S = 9'(EDGE + ENTRY);
  localparam logic [9:0] ENTRY_W = 10'(SCREEN_W - EDGE - ENTRY);
  localparam logic [9:0] ENTRY_E = 10'(EDGE + ENTRY);

  // One extra bit keeps 0-1 and 15+1 negative, so they can never alias onto a real room.
  function automatic logic signed [4:0] stepCoord(input logic [3:0] c, input logic signed [4:0] delta);
    return $signed({1'b0, c}) + delta;
  endfunction

  tracker_state_t state, stateNext;
  logic [9:0]     snapX;
  logic [8:0]     snapY;
  dir_t           dirNow, dirReg;
  logic [3:0]     destX, destY;
  logic signed [4:0] candX, candY;
  logic           moveOk;
  logic [HW-1:0]  holdCnt;

  edge_detect #(
    .SCREEN_W(SCREEN_W),
    .SCREEN_H(SCREEN_H),
    .EDGE    (EDGE)
  ) u_edge (
    .posX(snapX),
    .posY(snapY),
    .dir (dirNow)
  );

  always_comb begin
    candX = stepCoord(mapX, 5'sd0);
    candY = stepCoord(mapY, 5'sd0);
    case (dirReg)
      DIR_N:   candY = stepCoord(mapY, -5'sd1);
      DIR_S:   candY = stepCoord(mapY, 5'sd1);
      DIR_W:   candX = stepCoord(mapX, -5'sd1);
      DIR_E:   candX = stepCoord(mapX, 5'sd1);
      default: ;
    endcase
    moveOk = (dirReg != DIR_NONE) && !candX[4] && !candY[4] && room_exists(candX[3:0], candY[3:0]);
  end

  always_comb begin
    stateNext = state;
    case (state)
      ST_IDLE:     if (frame_tick) stateNext = ST_CHECK;
      ST_CHECK:    stateNext = (dirNow == DIR_NONE) ? ST_IDLE : ST_LOOKUP;
      ST_LOOKUP:   stateNext = moveOk ? ST_COMMIT : ST_IDLE;
      ST_COMMIT:   stateNext = ST_WAIT_ACK;
      ST_WAIT_ACK: if (warp_ack) stateNext = ST_HOLDOFF;
      ST_HOLDOFF:  if (holdCnt == '0) stateNext = ST_IDLE;
      default:     stateNext = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_vga or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= stateNext;
  end

  // Snapshot and lookup pipeline: only ever read after being written in the same transition.
  always_ff @(posedge clk_vga) begin
    if (state == ST_IDLE && frame_tick) begin
      snapX <= playerX;
      snapY <= playerY;
    end
    if (state == ST_CHECK) dirReg <= dirNow;
    if (state == ST_LOOKUP) begin
      destX <= candX[3:0];
      destY <= candY[3:0];
    end
  end

  always_ff @(posedge clk_vga or negedge reset) begin
    if (!reset) begin
      mapX       <= 4'(START_X);
      mapY       <= 4'(START_Y);
      warp_valid <= 1'b0;
      warpX      <= '0;
      warpY      <= '0;
      holdCnt    <= '0;
    end else begin
      case (state)
        ST_COMMIT: begin
          mapX       <= destX;
          mapY       <= destY;
          warp_valid <= 1'b1;
          warpX      <= snapX;
          warpY      <= snapY;
          case (dirReg)
            DIR_N:   warpY <= ENTRY_N;
            DIR_S:   warpY <= ENTRY_S;
            DIR_W:   warpX <= ENTRY_W;
            DIR_E:   warpX <= ENTRY_E;
            default: ;
          endcase
        end
        ST_WAIT_ACK: begin
          if (warp_ack) begin
            warp_valid <= 1'b0;
            holdCnt    <= HW'(HOLDOFF);
          end
        end
        ST_HOLDOFF: begin
          if (frame_tick && holdCnt != '0) holdCnt <= holdCnt - HW'(1);
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);

endmodule

// File: tb/tb_room_tracker.sv
// Directed bench for room_tracker: walks the room graph and checks handshake, hold-off and reset.
module tb_room_tracker;

  logic       clk_vga = 1'b0;
  logic       reset = 1'b0;
  logic       frame_tick = 1'b0;
  logic       warp_ack = 1'b0;
  logic [9:0] playerX = 10'd320;
  logic [8:0] playerY = 9'd240;
  logic [3:0] mapX, mapY;
  logic       warp_valid;
  logic [9:0] warpX;
  logic [8:0] warpY;
  logic       busy;

  int errors = 0;
  int checks = 0;

  always #5 clk_vga = ~clk_vga;

  room_tracker dut (
    .clk_vga   (clk_vga),
    .reset     (reset),
    .frame_tick(frame_tick),
    .playerX   (playerX),
    .playerY   (playerY),
    .warp_ack  (warp_ack),
    .mapX      (mapX),
    .mapY      (mapY),
    .warp_valid(warp_valid),
    .warpX     (warpX),
    .warpY     (warpY),
    .busy      (busy)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_vga);
      #1;
    end
  endtask

  task automatic pulseTick();
    frame_tick = 1'b1;
    step(1);
    frame_tick = 1'b0;
  endtask

  task automatic drainHold();
    playerX = 10'd320;
    playerY = 9'd240;
    repeat (8) begin
      pulseTick();
      step(2);
    end
    step(2);
  endtask

  task automatic moveAndAck(input logic [9:0] px, input logic [8:0] py);
    playerX = px;
    playerY = py;
    pulseTick();
    step(3);
    warp_ack = 1'b1;
    step(1);
    warp_ack = 1'b0;
    drainHold();
  endtask

  task automatic test_reset();
    step(2);
    reset = 1'b1;
    step(3);
    checks++;
    if (mapX !== 4'd3 || mapY !== 4'd5) begin
      errors++;
      $display("FAIL reset_map: got (%0d,%0d) want (3,5)", mapX, mapY);
    end
    checks++;
    if (warp_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: got valid=%b busy=%b want 0 0", warp_valid, busy);
    end
    checks++;
    if (warpX !== 10'd0 || warpY !== 9'd0) begin
      errors++;
      $display("FAIL reset_warp: got (%0d,%0d) want (0,0)", warpX, warpY);
    end
  endtask

  task automatic test_south();
    playerX = 10'd300;
    playerY = 9'd478;
    pulseTick();
    step(2);
    checks++;
    if (mapY !== 4'd5 || warp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL south_early: got mapY=%0d valid=%b busy=%b want 5 0 1", mapY, warp_valid, busy);
    end
    step(1);
    checks++;
    if (mapX !== 4'd3 || mapY !== 4'd6 || warp_valid !== 1'b1) begin
      errors++;
      $display("FAIL south_commit: got (%0d,%0d) valid=%b want (3,6) 1", mapX, mapY, warp_valid);
    end
    checks++;
    if (warpX !== 10'd300 || warpY !== 9'd20) begin
      errors++;
      $display("FAIL south_warp: got (%0d,%0d) want (300,20)", warpX, warpY);
    end
    playerX = 10'd100;
    playerY = 9'd100;
    for (int i = 0; i < 10; i++) begin
      frame_tick = (i == 4);
      step(1);
      checks++;
      if (warp_valid !== 1'b1 || warpX !== 10'd300 || warpY !== 9'd20 || mapY !== 4'd6) begin
        errors++;
        $display("FAIL south_hold[%0d]: got valid=%b warp=(%0d,%0d) mapY=%0d want 1 (300,20) 6",
                 i, warp_valid, warpX, warpY, mapY);
      end
    end
    frame_tick = 1'b0;
    warp_ack = 1'b1;
    step(1);
    warp_ack = 1'b0;
    checks++;
    if (warp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL south_ack: got valid=%b busy=%b want 0 1", warp_valid, busy);
    end
    drainHold();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL south_drain: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_west_holdoff();
    playerX = 10'd2;
    playerY = 9'd240;
    pulseTick();
    step(3);
    checks++;
    if (mapX !== 4'd2 || mapY !== 4'd6 || warp_valid !== 1'b1 || warpX !== 10'd620 || warpY !== 9'd240) begin
      errors++;
      $display("FAIL west_commit: got (%0d,%0d) valid=%b warp=(%0d,%0d) want (2,6) 1 (620,240)",
               mapX, mapY, warp_valid, warpX, warpY);
    end
    warp_ack = 1'b1;
    step(1);
    warp_ack = 1'b0;
    playerX = 10'd637;
    for (int t = 1; t <= 8; t++) begin
      pulseTick();
      step(3);
      checks++;
      if (mapX !== 4'd2 || warp_valid !== 1'b0) begin
        errors++;
        $display("FAIL holdoff_tick%0d: got mapX=%0d valid=%b want 2 0", t, mapX, warp_valid);
      end
    end
    pulseTick();
    step(3);
    checks++;
    if (mapX !== 4'd3 || mapY !== 4'd6 || warp_valid !== 1'b1 || warpX !== 10'd20 || warpY !== 9'd240) begin
      errors++;
      $display("FAIL east_commit: got (%0d,%0d) valid=%b warp=(%0d,%0d) want (3,6) 1 (20,240)",
               mapX, mapY, warp_valid, warpX, warpY);
    end
    warp_ack = 1'b1;
    step(1);
    warp_ack = 1'b0;
    drainHold();
  endtask

  task automatic test_corner();
    playerX = 10'd1;
    playerY = 9'd1;
    pulseTick();
    step(3);
    checks++;
    if (mapX !== 4'd2 || mapY !== 4'd4 || warpX !== 10'd1 || warpY !== 9'd460) begin
      errors++;
      $display("FAIL corner: got (%0d,%0d) warp=(%0d,%0d) want (2,4) (1,460)", mapX, mapY, warpX, warpY);
    end
    warp_ack = 1'b1;
    step(1);
    warp_ack = 1'b0;
    drainHold();
  endtask

  task automatic test_thresholds();
    playerX = 10'd4;
    playerY = 9'd4;
    pulseTick();
    step(1);
    checks++;
    if (busy !== 1'b0 || mapX !== 4'd1 || mapY !== 4'd2) begin
      errors++;
      $display("FAIL thresh_lo: got busy=%b map=(%0d,%0d) want 0 (1,2)", busy, mapX, mapY);
    end
    playerX = 10'd635;
    playerY = 9'd475;
    pulseTick();
    step(1);
    checks++;
    if (busy !== 1'b0 || mapX !== 4'd1 || mapY !== 4'd2) begin
      errors++;
      $display("FAIL thresh_hi: got busy=%b map=(%0d,%0d) want 0 (1,2)", busy, mapX, mapY);
    end
  endtask

  task automatic test_no_room();
    playerX = 10'd1;
    playerY = 9'd1;
    pulseTick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL noroom_busy0: got busy=%b want 1", busy);
    end
    step(1);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL noroom_busy1: got busy=%b want 1", busy);
    end
    step(1);
    checks++;
    if (busy !== 1'b0 || mapX !== 4'd1 || mapY !== 4'd2 || warp_valid !== 1'b0) begin
      errors++;
      $display("FAIL noroom_north: got busy=%b map=(%0d,%0d) valid=%b want 0 (1,2) 0",
               busy, mapX, mapY, warp_valid);
    end
    playerX = 10'd1;
    playerY = 9'd240;
    pulseTick();
    step(4);
    checks++;
    if (busy !== 1'b0 || mapX !== 4'd1 || mapY !== 4'd2 || warp_valid !== 1'b0) begin
      errors++;
      $display("FAIL noroom_west: got busy=%b map=(%0d,%0d) valid=%b want 0 (1,2) 0",
               busy, mapX, mapY, warp_valid);
    end
  endtask

  task automatic test_ack_early();
    warp_ack = 1'b1;
    playerX = 10'd320;
    playerY = 9'd479;
    pulseTick();
    step(2);
    checks++;
    if (warp_valid !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL early_pre: got valid=%b busy=%b want 0 1", warp_valid, busy);
    end
    step(1);
    checks++;
    if (warp_valid !== 1'b1 || mapY !== 4'd3 || warpY !== 9'd20 || warpX !== 10'd320) begin
      errors++;
      $display("FAIL early_commit: got valid=%b mapY=%0d warp=(%0d,%0d) want 1 3 (320,20)",
               warp_valid, mapY, warpX, warpY);
    end
    step(1);
    checks++;
    if (warp_valid !== 1'b0) begin
      errors++;
      $display("FAIL early_ack: got valid=%b want 0", warp_valid);
    end
    warp_ack = 1'b0;
    drainHold();
  endtask

  task automatic test_reset_mid();
    reset = 1'b0;
    #1;
    checks++;
    if (mapX !== 4'd3 || mapY !== 4'd5) begin
      errors++;
      $display("FAIL rst_idle: got (%0d,%0d) want (3,5)", mapX, mapY);
    end
    reset = 1'b1;
    step(1);
    playerX = 10'd300;
    playerY = 9'd478;
    pulseTick();
    step(4);
    checks++;
    if (warp_valid !== 1'b1 || mapY !== 4'd6 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_setup: got valid=%b mapY=%0d busy=%b want 1 6 1", warp_valid, mapY, busy);
    end
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (mapX !== 4'd3 || mapY !== 4'd5 || warp_valid !== 1'b0 || busy !== 1'b0 || warpY !== 9'd0) begin
      errors++;
      $display("FAIL rst_async: got (%0d,%0d) valid=%b busy=%b warpY=%0d want (3,5) 0 0 0",
               mapX, mapY, warp_valid, busy, warpY);
    end
    playerX = 10'd320;
    playerY = 9'd240;
    step(1);
    reset = 1'b1;
    step(4);
    checks++;
    if (warp_valid !== 1'b0 || busy !== 1'b0 || mapY !== 4'd5) begin
      errors++;
      $display("FAIL rst_after: got valid=%b busy=%b mapY=%0d want 0 0 5", warp_valid, busy, mapY);
    end
  endtask

  initial begin
    test_reset();
    test_south();
    test_west_holdoff();
    moveAndAck(10'd2, 9'd240);
    moveAndAck(10'd320, 9'd1);
    test_corner();
    moveAndAck(10'd2, 9'd240);
    moveAndAck(10'd320, 9'd1);
    moveAndAck(10'd320, 9'd1);
    test_thresholds();
    test_no_room();
    test_ack_early();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
